// File: rtl/adc_spi_reader_if.sv
// Controller-side handshake between daq_cntroller and adc_spi_reader:
// conversion request in, sample/done/status back.
interface adc_spi_reader_if;
  logic        adc_en;
  logic [11:0] adc_data;
  logic        adc_done;
  logic        frame_err;
  logic        busy;

  modport master (
    output adc_en,
    input  adc_data,
    input  adc_done,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  adc_en,
    output adc_data,
    output adc_done,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/adc_spi_reader.sv
// SPI mode-0 reader for the 12-bit ADC: one 16-bit MSB-first frame per request,
// returns the low 12 bits plus a leading-bit error flag. All outputs registered.
module adc_spi_reader #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  adc_spi_reader_if.slave   bus,
  input  logic              miso,
  output logic              cs_n,
  output logic              sclk
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_QUIET = 3'd5;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 32'd1);
  localparam logic [4:0] HALF_LAST = 5'd31;

  // Any of the four leading frame bits set means the ADC framing is off
  function automatic logic lead_err(input logic [15:0] frame);
    return |frame[15:12];
  endfunction

  logic [2:0]  state_r, state_nxt_s;
  logic [7:0]  div_r, div_nxt_s;
  logic [4:0]  half_r, half_nxt_s;
  logic [15:0] shift_r, shift_nxt_s;
  logic        div_last_s;
  logic        sample_s;
  logic        cs_n_r, cs_n_nxt_s;
  logic        sclk_r, sclk_nxt_s;
  logic        done_r, done_nxt_s;
  logic        busy_r, busy_nxt_s;
  logic        err_r, err_nxt_s;
  logic [11:0] data_r, data_nxt_s;

  assign div_last_s = (div_r == DIV_LAST);

  // Next-state selection; QUIET hands straight to CS_SETUP when a request is pending
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.adc_en) state_nxt_s = ST_SETUP;
        else            state_nxt_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (div_last_s) state_nxt_s = ST_SHIFT;
        else            state_nxt_s = ST_SETUP;
      end
      ST_SHIFT: begin
        if (div_last_s && (half_r == HALF_LAST)) state_nxt_s = ST_HOLD;
        else                                     state_nxt_s = ST_SHIFT;
      end
      ST_HOLD: begin
        if (div_last_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_HOLD;
      end
      ST_DONE: state_nxt_s = ST_QUIET;
      ST_QUIET: begin
        if (div_last_s) begin
          if (bus.adc_en) state_nxt_s = ST_SETUP;
          else            state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_QUIET;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Divider and half-bit counters, both cleared on every state entry
  always_comb begin
    div_nxt_s  = div_r;
    half_nxt_s = half_r;
    if (state_nxt_s != state_r) begin
      div_nxt_s  = 8'd0;
      half_nxt_s = 5'd0;
    end else if (state_r == ST_IDLE) begin
      div_nxt_s  = 8'd0;
      half_nxt_s = 5'd0;
    end else if (div_last_s) begin
      div_nxt_s  = 8'd0;
      half_nxt_s = half_r + 5'd1;
    end else begin
      div_nxt_s  = div_r + 8'd1;
      half_nxt_s = half_r;
    end
  end

  // Sample miso on the edge that raises sclk (end of an even half-bit)
  always_comb begin
    sample_s    = (state_r == ST_SHIFT) && div_last_s && !half_r[0];
    shift_nxt_s = shift_r;
    if (sample_s) shift_nxt_s = {shift_r[14:0], miso};
    else          shift_nxt_s = shift_r;
  end

  // Output values derived from the next state so every output is a flop
  always_comb begin
    cs_n_nxt_s = !((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_SHIFT) ||
                   (state_nxt_s == ST_HOLD));
    sclk_nxt_s = (state_nxt_s == ST_SHIFT) && half_nxt_s[0];
    done_nxt_s = (state_nxt_s == ST_DONE);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    data_nxt_s = data_r;
    err_nxt_s  = err_r;
    if (done_nxt_s) begin
      data_nxt_s = shift_r[11:0];
      err_nxt_s  = lead_err(shift_r);
    end else begin
      data_nxt_s = data_r;
      err_nxt_s  = err_r;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      div_r   <= 8'd0;
      half_r  <= 5'd0;
      shift_r <= 16'h0000;
      cs_n_r  <= 1'b1;
      sclk_r  <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      data_r  <= 12'h000;
    end else begin
      state_r <= state_nxt_s;
      div_r   <= div_nxt_s;
      half_r  <= half_nxt_s;
      shift_r <= shift_nxt_s;
      cs_n_r  <= cs_n_nxt_s;
      sclk_r  <= sclk_nxt_s;
      done_r  <= done_nxt_s;
      busy_r  <= busy_nxt_s;
      err_r   <= err_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign cs_n          = cs_n_r;
  assign sclk          = sclk_r;
  assign bus.adc_done  = done_r;
  assign bus.busy      = busy_r;
  assign bus.frame_err = err_r;
  assign bus.adc_data  = data_r;

endmodule
